// File: rtl/mixer_xfade.sv
// Dry/wet mixer: programmable wet gain with per-sample ramping, crossfade or
// additive mode, round-half-up with saturation, 2-stage valid-strobed pipeline.
module mixer_xfade #(
  parameter int WIDTH     = 16,
  parameter int COEF_W    = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  pktDry_i,
  input  logic [WIDTH-1:0]  pktWet_i,
  input  logic              valid_i,
  input  logic [COEF_W:0]   mixTarget_i,
  input  logic              mode_i,
  output logic [WIDTH-1:0]  pktMixed_o,
  output logic              valid_o,
  output logic              clip_o,
  output logic              ramping_o
);

  localparam int PW = WIDTH + COEF_W + 2;
  localparam int SW = PW + 1;
  localparam logic [COEF_W:0]        FULL = {1'b1, {COEF_W{1'b0}}};
  localparam logic [COEF_W:0]        STEP = (COEF_W+1)'(RAMP_STEP);
  localparam logic signed [SW-1:0]   HALF = SW'(2**(COEF_W-1));
  localparam logic signed [SW-1:0]   MAXV = SW'(2**(WIDTH-1) - 1);
  localparam logic signed [SW-1:0]   MINV = SW'(-(2**(WIDTH-1)));

  logic [COEF_W:0] gCur_q, gCur_d, tClamp, diffUp, diffDn;

  always_comb begin
    tClamp = (mixTarget_i > FULL) ? FULL : mixTarget_i;
  end

  // Ramp moves toward the clamped target from wherever gCur currently sits.
  always_comb begin
    gCur_d = gCur_q;
    diffUp = tClamp - gCur_q;
    diffDn = gCur_q - tClamp;
    if (valid_i) begin
      if (RAMP_STEP == 0)
        gCur_d = tClamp;
      else if (tClamp >= gCur_q)
        gCur_d = (diffUp <= STEP) ? tClamp : gCur_q + STEP;
      else
        gCur_d = (diffDn <= STEP) ? tClamp : gCur_q - STEP;
    end
  end

  assign ramping_o = (gCur_q != tClamp);

  logic signed [PW-1:0] dryX, wetX, gW, gD, pW_d, pD_d, pW_q, pD_q;
  logic                 v1_q;

  always_comb begin
    dryX = PW'($signed(pktDry_i));
    wetX = PW'($signed(pktWet_i));
    gW   = PW'(gCur_q);
    gD   = mode_i ? PW'(FULL) : PW'(FULL - gCur_q);
    pW_d = wetX * gW;
    pD_d = dryX * gD;
  end

  logic signed [SW-1:0] sum, shr;
  logic [WIDTH-1:0]     mix_d, mix_q;
  logic                 clip_d, clip_q, valid_q;

  always_comb begin
    sum    = SW'(pW_q) + SW'(pD_q) + HALF;
    shr    = sum >>> COEF_W;
    mix_d  = WIDTH'(shr);
    clip_d = 1'b0;
    if (shr > MAXV) begin
      mix_d  = WIDTH'(MAXV);
      clip_d = 1'b1;
    end else if (shr < MINV) begin
      mix_d  = WIDTH'(MINV);
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gCur_q  <= '0;
      pW_q    <= '0;
      pD_q    <= '0;
      v1_q    <= 1'b0;
      mix_q   <= '0;
      clip_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      gCur_q  <= gCur_d;
      v1_q    <= valid_i;
      valid_q <= v1_q;
      if (valid_i) begin
        pW_q <= pW_d;
        pD_q <= pD_d;
      end
      if (v1_q) begin
        mix_q  <= mix_d;
        clip_q <= clip_d;
      end
    end
  end

  assign pktMixed_o = mix_q;
  assign clip_o     = clip_q;
  assign valid_o    = valid_q;

endmodule
